// File: rtl/scratchmem_arbiter.sv
// scratchmem_arbiter: two-master Wishbone arbiter that shares the on-chip
// scratchpad between instruction fetch (m0) and data/DMA (m1).
// A master keeps the bus for as long as it holds cyc, so a burst is never
// split. Every change of owner passes through one GAP cycle with the slave
// port idle, so the scratchpad sees a fresh cs edge and reloads its address.
// Optional build macro: SCRATCHARB_TIMEOUT_EN adds m0_err_o/m1_err_o and a
// wait-state watchdog that flags an owner the slave leaves waiting for
// TMO_CYCLES strobed cycles.
module scratchmem_arbiter #(
   parameter int DBW        = 32,
   parameter int ABW        = 32,
   parameter int TMO_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   // master 0: instruction fetch
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [DBW/8-1:0] m0_sel_i,
   input  logic [ABW-1:0]   m0_adr_i,
   input  logic [DBW-1:0]   m0_dat_i,
   output logic             m0_ack_o,
   output logic [DBW-1:0]   m0_dat_o,
   // master 1: data / DMA
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [DBW/8-1:0] m1_sel_i,
   input  logic [ABW-1:0]   m1_adr_i,
   input  logic [DBW-1:0]   m1_dat_i,
   output logic             m1_ack_o,
   output logic [DBW-1:0]   m1_dat_o,
   // scratchpad slave port
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [DBW/8-1:0] s_sel_o,
   output logic [ABW-1:0]   s_adr_o,
   output logic [DBW-1:0]   s_dat_o,
`ifdef SCRATCHARB_TIMEOUT_EN
   output logic             m0_err_o,
   output logic             m1_err_o,
`endif
   input  logic             s_ack_i,
   input  logic [DBW-1:0]   s_dat_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t state_q;
   // Master that was granted most recently; the other one wins a tie.
   logic   last_grant_q;

   // Arbitration request decode. m0 wins when it is alone, or on a tie when
   // m1 was the previous owner; m1 wins otherwise whenever it requests.
   logic   pick_m0;
   logic   pick_m1;

   assign pick_m0 = m0_cyc_i & (~m1_cyc_i | last_grant_q);
   assign pick_m1 = m1_cyc_i & ~pick_m0;

   // The watchdog counter is 8 bits wide, so the limit must fit in it.
   if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
      $error("scratchmem_arbiter: TMO_CYCLES must be in 1..255");
   end

   // Grant FSM: IDLE and GAP both arbitrate (GAP is the forced idle cycle after
   // a release); an owner keeps the bus until it drops cyc.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE, GAP: begin
               if (pick_m0) begin
                  state_q      <= OWN0;
                  last_grant_q <= 1'b0;
               end else if (pick_m1) begin
                  state_q      <= OWN1;
                  last_grant_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            OWN0: begin
               if (!m0_cyc_i) begin
                  state_q <= GAP;
               end
            end
            OWN1: begin
               if (!m1_cyc_i) begin
                  state_q <= GAP;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Bus steering: only the registered owner reaches the slave, and only the
   // owner sees ack and read data; everything is quiet in IDLE and GAP.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_dat_o = '0;
      case (state_q)
         OWN0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i & m0_cyc_i & m0_stb_i;
            m0_dat_o = s_dat_i;
         end
         OWN1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i & m1_cyc_i & m1_stb_i;
            m1_dat_o = s_dat_i;
         end
         default: begin
         end
      endcase
   end

`ifdef SCRATCHARB_TIMEOUT_EN
   logic [7:0] wait_q;
   logic       err0_q;
   logic       err1_q;
   logic       own_stay;
   logic       own_stb;
   logic       fwd_ack;

   // own_stay is true only when the FSM keeps the same owner at this edge;
   // any other edge is a state change and restarts the count.
   assign own_stay = ((state_q == OWN0) &&  m0_cyc_i) ||
                     ((state_q == OWN1) &&  m1_cyc_i);
   assign own_stb  = ((state_q == OWN0) &&  m0_stb_i) ||
                     ((state_q == OWN1) &&  m1_stb_i);
   assign fwd_ack  = m0_ack_o | m1_ack_o;

   // Wait-state watchdog: count strobed cycles without ack; on reaching the
   // limit pulse the owner's err for one cycle and restart, keeping the grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_q <= '0;
         err0_q <= 1'b0;
         err1_q <= 1'b0;
      end else begin
         err0_q <= 1'b0;
         err1_q <= 1'b0;
         if (!own_stay || fwd_ack) begin
            wait_q <= '0;
         end else if (own_stb && !s_ack_i) begin
            if (wait_q == 8'(TMO_CYCLES - 1)) begin
               wait_q <= '0;
               err0_q <= (state_q == OWN0);
               err1_q <= (state_q == OWN1);
            end else begin
               wait_q <= wait_q + 8'd1;
            end
         end
      end
   end

   assign m0_err_o = err0_q;
   assign m1_err_o = err1_q;
`endif

endmodule

// File: doc/scratchmem_arbiter.md
Name: scratchmem_arbiter

Overview:
Two-master Wishbone arbiter that shares the 32-bit on-chip scratchpad between the instruction-fetch port (m0) and the data/DMA port (m1).
- Grants whole bus cycles (cyc held = burst lock), so the scratchpad's sequential read-address counter stays valid for a burst.
- Forces a one-cycle idle gap between owners so the scratchpad sees a fresh cs rising edge and reloads its address.
- Sits between the two masters and the single scratchpad slave port.

Parameters:
DBW, 32, data bus width; sel width is DBW/8.
ABW, 32, address bus width.
TMO_CYCLES, 255, wait-state limit before an error ack; used only with SCRATCHARB_TIMEOUT_EN.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  synchronous active-high reset.
m0_cyc_i, m1_cyc_i  input  1 each  master bus-cycle request; held high for a burst.
m0_stb_i, m1_stb_i  input  1 each  master strobe.
m0_we_i, m1_we_i  input  1 each  master write enable.
m0_sel_i, m1_sel_i  input  DBW/8 each  byte selects.
m0_adr_i, m1_adr_i  input  ABW each  byte address.
m0_dat_i, m1_dat_i  input  DBW each  write data.
m0_ack_o, m1_ack_o  output  1 each  ack; only the owner's ack is ever high.
m0_dat_o, m1_dat_o  output  DBW each  read data; zero when not the owner.
s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle, strobe and write enable.
s_sel_o  output  DBW/8  slave byte selects.
s_adr_o  output  ABW  slave address.
s_dat_o  output  DBW  slave write data.
s_ack_i  input  1  slave ack.
s_dat_i  input  DBW  slave read data.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high (clk_i, rst_i).
  - Reset takes effect at the next clk_i edge and forces state IDLE and last_grant=1, so m0 wins the first tie.
  - After reset, all s_* outputs, mN_ack_o and mN_dat_o are 0.
- State register: IDLE, OWN0, OWN1, GAP. All outputs are combinational from the registered state plus the owner's inputs. Master and slave inputs are never combined with the grant decision in the same cycle.
- IDLE transitions:
  - Only m0_cyc_i high -> OWN0.
  - Only m1_cyc_i high -> OWN1.
  - Both high -> the master not equal to last_grant wins.
  - Neither high -> stay in IDLE.
  - Latency: a request seen at edge t gives s_cyc_o high in cycle t+1.
- OWNn:
  - Slave outputs mirror master n: s_cyc_o=mn_cyc_i, s_stb_o=mn_stb_i, and we/sel/adr/dat pass through.
  - mn_ack_o = s_ack_i & mn_cyc_i & mn_stb_i; mn_dat_o = s_dat_i.
  - The other master gets ack 0 and dat 0.
  - last_grant <= n on entry.
  - mn_cyc_i low at an edge -> GAP. A pending request from the other master does not preempt the owner.
- GAP: exactly one cycle with all s_* = 0 and both acks 0, then -> IDLE arbitration on the next edge. Minimum owner turnaround is therefore IDLE->OWN, 2 cycles after release.
- The owner may toggle stb inside cyc; the grant holds and no gap is inserted.
- s_ack_i high while in IDLE or GAP is ignored and not forwarded.
- Reset mid-burst: the grant drops at that edge, s_cyc_o=0 the following cycle, and no ack is forwarded after reset is sampled.
- Master dropping cyc in the same cycle as s_ack_i: the ack is still forwarded that cycle because its cyc was high.

Optional Feature:
SCRATCHARB_TIMEOUT_EN
- Defined:
  - Ports m0_err_o and m1_err_o (1 bit each) exist, reset 0.
  - An 8-bit wait counter clears on every forwarded ack and on every state change, and increments each OWNn cycle with mn_stb_i=1 and s_ack_i=0.
  - When it reaches TMO_CYCLES, mn_err_o pulses for one cycle, the counter clears, and the grant is kept (the master must drop cyc).
- Not defined: no err ports, no counter, and owners may wait indefinitely.

Test Plan:
- Reset then m0 read burst: m0 cyc/stb held 4 beats at adr 0x100 -> s_cyc_o high 1 cycle after request; 4 m0 acks with data from 0x100..0x10C; m1_ack_o=0 throughout.
- Simultaneous requests after reset: m0 and m1 raise cyc at the same edge -> m0 owns first. m0 drops cyc -> exactly 1 GAP cycle with s_cyc_o=0, then m1 owns.
- Round robin: both masters keep re-requesting single-beat writes (sel=4'hF, dat 0xDEADBEEF/0x12345678) -> ownership alternates m0,m1,m0,m1 with a GAP between each.
- No preemption: m1 requests during a 10-beat m0 burst -> m1 gets no ack until m0 drops cyc; m1 owns 2 cycles after the release edge.
- Reset mid-burst: rst_i pulsed during beat 2 of an m1 read -> s_cyc_o=0 the next cycle, no further m1 ack, state IDLE, next tie goes to m0.
- Timeout (macro on, TMO_CYCLES=8): slave never acks an m0 stb -> m0_err_o pulses once after 8 wait cycles, and again after 8 more if stb stays high.
